// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared encodings for the MIPS write-back stage: write-back source select
// (WBSel) and load type (LoadType) values, plus a small extension helper.
// Optional feature macro used by the stage: WB_RETIRE_CNT_EN.
// -----------------------------------------------------------------------------
package wb_stage_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_MEM  = 2'b01,
      WB_LINK = 2'b10,
      WB_RSVD = 2'b11
   } wbsel_e;

   typedef enum logic [2:0] {
      LD_W  = 3'b000,
      LD_B  = 3'b001,
      LD_BU = 3'b010,
      LD_H  = 3'b011,
      LD_HU = 3'b100
   } ldtype_e;

   // Sign- or zero-extend a sub-word of width w (8 or 16) held in the low bits.
   function automatic logic [31:0] ext_sub(input logic [15:0] val, input logic is_half,
                                           input logic sgn);
      logic [31:0] r;
      if (is_half) r = {{16{sgn & val[15]}}, val};
      else         r = {{24{sgn & val[7]}}, val[7:0]};
      return r;
   endfunction

endpackage

// File: rtl/wb_stage_load_ext.sv
// -----------------------------------------------------------------------------
// wb_stage_load_ext
// Combinational load-data extraction: picks the byte/half selected by the low
// address bits out of the aligned DM word and sign/zero extends it.
// Ports:
//   mem_rd_i    [31:0] raw aligned word from data memory
//   addr_lo_i   [1:0]  low two bits of the load address
//   load_type_i [2:0]  LoadType encoding (unknown codes behave as lw)
//   data_o      [31:0] extended load result
// -----------------------------------------------------------------------------
module wb_stage_load_ext
   import wb_stage_pkg::*;
(
   input  logic [31:0] mem_rd_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  load_type_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = mem_rd_i[8*addr_lo_i +: 8];
   // Halfword choice uses only addr_lo[1]; misaligned bit 0 is ignored.
   assign half_sel = addr_lo_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

   always_comb begin
      data_o = mem_rd_i;
      case (load_type_i)
         LD_B:    data_o = ext_sub({8'h00, byte_sel}, 1'b0, 1'b1);
         LD_BU:   data_o = ext_sub({8'h00, byte_sel}, 1'b0, 1'b0);
         LD_H:    data_o = ext_sub(half_sel, 1'b1, 1'b1);
         LD_HU:   data_o = ext_sub(half_sel, 1'b1, 1'b0);
         default: data_o = mem_rd_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage of the 5-stage MIPS pipeline. Holds the M/W register,
// extracts load data, selects the write-back value and drives the ID-stage
// GRF write port (written on the following negedge) and the W forwarding value.
// Optional macro WB_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
// Ports:
//   clk, reset (async, active-low)
//   M_instruc, M_PC, M_WRA, M_ALUOut, M_MemRD, M_WBSel, M_LoadType : from M
//   W_hold (freeze), W_flush (load nop)
//   W_WRA, W_WRD, W_PCWhenWrite : GRF write port / trace
//   W_instruc, W_Pass, W_WRA_fwd : to hazard unit
//   W_retire_cnt (only with WB_RETIRE_CNT_EN)
// -----------------------------------------------------------------------------
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int unsigned RA_IDX      = 31,
   parameter logic [31:0] PC_LINK_OFS = 32'd8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [31:0]                      M_instruc,
   input  logic [31:0]                      M_PC,
   input  logic [$clog2(RA_IDX+1)-1:0]      M_WRA,
   input  logic [31:0]                      M_ALUOut,
   input  logic [31:0]                      M_MemRD,
   input  logic [1:0]                       M_WBSel,
   input  logic [2:0]                       M_LoadType,
   input  logic                             W_hold,
   input  logic                             W_flush,
   output logic [$clog2(RA_IDX+1)-1:0]      W_WRA,
   output logic [31:0]                      W_WRD,
   output logic [31:0]                      W_PCWhenWrite,
   output logic [31:0]                      W_instruc,
   output logic [31:0]                      W_Pass,
`ifdef WB_RETIRE_CNT_EN
   output logic [31:0]                      W_retire_cnt,
`endif
   output logic [$clog2(RA_IDX+1)-1:0]      W_WRA_fwd
);

   // Register-address width follows the link register index.
   localparam int unsigned AW = $clog2(RA_IDX + 1);

   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pc_q, pc_d;
   logic [AW-1:0] wra_q, wra_d;
   logic [31:0]   alu_q, alu_d;
   logic [31:0]   mem_q, mem_d;
   logic [1:0]    wbsel_q, wbsel_d;
   logic [2:0]    ldtype_q, ldtype_d;
   logic [1:0]    addr_lo_q, addr_lo_d;
   logic          written_q, written_d;
   logic [31:0]   load_data;

   always_comb begin
      instr_d   = instr_q;
      pc_d      = pc_q;
      wra_d     = wra_q;
      alu_d     = alu_q;
      mem_d     = mem_q;
      wbsel_d   = wbsel_q;
      ldtype_d  = ldtype_q;
      addr_lo_d = addr_lo_q;
      written_d = 1'b0;
      if (W_hold) begin
         // Once the GRF has taken the write, suppress it for the rest of the hold.
         written_d = written_q | (wra_q != '0);
      end else if (W_flush) begin
         instr_d   = '0;
         pc_d      = '0;
         wra_d     = '0;
         alu_d     = '0;
         mem_d     = '0;
         wbsel_d   = '0;
         ldtype_d  = '0;
         addr_lo_d = '0;
      end else begin
         instr_d   = M_instruc;
         pc_d      = M_PC;
         wra_d     = M_WRA;
         alu_d     = M_ALUOut;
         mem_d     = M_MemRD;
         wbsel_d   = M_WBSel;
         ldtype_d  = M_LoadType;
         addr_lo_d = M_ALUOut[1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q   <= '0;
         pc_q      <= '0;
         wra_q     <= '0;
         alu_q     <= '0;
         mem_q     <= '0;
         wbsel_q   <= '0;
         ldtype_q  <= '0;
         addr_lo_q <= '0;
         written_q <= 1'b0;
      end else begin
         instr_q   <= instr_d;
         pc_q      <= pc_d;
         wra_q     <= wra_d;
         alu_q     <= alu_d;
         mem_q     <= mem_d;
         wbsel_q   <= wbsel_d;
         ldtype_q  <= ldtype_d;
         addr_lo_q <= addr_lo_d;
         written_q <= written_d;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_q, retire_d;

   // An instruction retires when it leaves W, i.e. on any un-held edge.
   always_comb begin
      retire_d = retire_q;
      if (!W_hold && (instr_q != '0)) retire_d = retire_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) retire_q <= '0;
      else        retire_q <= retire_d;
   end

   assign W_retire_cnt = retire_q;
`endif

   wb_stage_load_ext u_load_ext (
      .mem_rd_i    (mem_q),
      .addr_lo_i   (addr_lo_q),
      .load_type_i (ldtype_q),
      .data_o      (load_data)
   );

   always_comb begin
      case (wbsel_q)
         WB_ALU:  W_WRD = alu_q;
         WB_MEM:  W_WRD = load_data;
         WB_LINK: W_WRD = pc_q + PC_LINK_OFS;
         default: W_WRD = '0;
      endcase
   end

   assign W_WRA         = written_q ? '0 : wra_q;
   assign W_WRA_fwd     = wra_q;
   assign W_PCWhenWrite = pc_q;
   assign W_instruc     = instr_q;
   assign W_Pass        = W_WRD;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   logic        clk;
   logic        reset;
   logic [31:0] M_instruc, M_PC, M_ALUOut, M_MemRD;
   logic [4:0]  M_WRA;
   logic [1:0]  M_WBSel;
   logic [2:0]  M_LoadType;
   logic        W_hold, W_flush;
   logic [4:0]  W_WRA, W_WRA_fwd;
   logic [31:0] W_WRD, W_PCWhenWrite, W_instruc, W_Pass;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] W_retire_cnt;
`endif

   int checks;
   int failures;

   wb_stage dut (
      .clk           (clk),
      .reset         (reset),
      .M_instruc     (M_instruc),
      .M_PC          (M_PC),
      .M_WRA         (M_WRA),
      .M_ALUOut      (M_ALUOut),
      .M_MemRD       (M_MemRD),
      .M_WBSel       (M_WBSel),
      .M_LoadType    (M_LoadType),
      .W_hold        (W_hold),
      .W_flush       (W_flush),
      .W_WRA         (W_WRA),
      .W_WRD         (W_WRD),
      .W_PCWhenWrite (W_PCWhenWrite),
      .W_instruc     (W_instruc),
      .W_Pass        (W_Pass),
`ifdef WB_RETIRE_CNT_EN
      .W_retire_cnt  (W_retire_cnt),
`endif
      .W_WRA_fwd     (W_WRA_fwd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (instruction-level view) ----------------
   logic [31:0] md_instr, md_pc, md_alu, md_mem, md_cnt;
   logic [4:0]  md_wra;
   logic [1:0]  md_sel;
   logic [2:0]  md_lt;
   bit          md_done;   // this instruction's GRF write already happened

   task automatic model_reset();
      md_instr = 0; md_pc = 0; md_alu = 0; md_mem = 0; md_cnt = 0;
      md_wra = 0; md_sel = 0; md_lt = 0; md_done = 0;
   endtask

   // Applies the M-side inputs and controls present at a clock edge.
   task automatic model_edge();
      if (W_hold) begin
         if (md_wra != 0) md_done = 1;
      end else begin
         if (md_instr != 0) md_cnt = md_cnt + 1;
         md_done = 0;
         if (W_flush) begin
            md_instr = 0; md_pc = 0; md_alu = 0; md_mem = 0;
            md_wra = 0; md_sel = 0; md_lt = 0;
         end else begin
            md_instr = M_instruc; md_pc = M_PC; md_alu = M_ALUOut; md_mem = M_MemRD;
            md_wra = M_WRA; md_sel = M_WBSel; md_lt = M_LoadType;
         end
      end
   endtask

   function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [2:0] lt,
                                            input logic [31:0] alu, input logic [31:0] mem,
                                            input logic [31:0] pc);
      int unsigned lo;
      logic [31:0] v;
      lo = alu % 4;
      if (sel == 2'd0) return alu;
      if (sel == 2'd2) return pc + 32'd8;
      if (sel == 2'd3) return 32'd0;
      case (lt)
         3'd1, 3'd2: begin
            v = (mem >> (8 * lo)) & 32'hFF;
            if (lt == 3'd1 && v >= 32'd128) v = v + 32'hFFFFFF00;
         end
         3'd3, 3'd4: begin
            v = (mem >> (16 * (lo / 2))) & 32'hFFFF;
            if (lt == 3'd3 && v >= 32'h8000) v = v + 32'hFFFF0000;
         end
         default: v = mem;
      endcase
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] d;
      d = ref_data(md_sel, md_lt, md_alu, md_mem, md_pc);
      chk({tag, ".W_WRA"}, {27'd0, W_WRA}, md_done ? 32'd0 : {27'd0, md_wra});
      chk({tag, ".W_WRA_fwd"}, {27'd0, W_WRA_fwd}, {27'd0, md_wra});
      chk({tag, ".W_WRD"}, W_WRD, d);
      chk({tag, ".W_Pass"}, W_Pass, d);
      chk({tag, ".W_PCWhenWrite"}, W_PCWhenWrite, md_pc);
      chk({tag, ".W_instruc"}, W_instruc, md_instr);
`ifdef WB_RETIRE_CNT_EN
      chk({tag, ".W_retire_cnt"}, W_retire_cnt, md_cnt);
`endif
   endtask

   task automatic set_m(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] wra,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [1:0] sel, input logic [2:0] lt);
      M_instruc = ins; M_PC = pc; M_WRA = wra; M_ALUOut = alu;
      M_MemRD = mem; M_WBSel = sel; M_LoadType = lt;
   endtask

   task automatic step(input bit hold, input bit flush);
      W_hold = hold; W_flush = flush;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [4:0]  wra;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [1:0]  sel;
      logic [2:0]  lt;
      logic [4:0]  exp_wra;
      logic [31:0] exp_wrd;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int writes;
      logic [31:0] held_instr;

      vecs[0] = '{"alu",       32'h0000_3000, 5'd5,  32'h0000_1234, 32'h0,         2'd0, 3'd0, 5'd5,  32'h0000_1234};
      vecs[1] = '{"lb3",       32'h0000_3004, 5'd6,  32'h0000_0103, 32'h80FF_7F01, 2'd1, 3'd1, 5'd6,  32'hFFFF_FF80};
      vecs[2] = '{"lbu3",      32'h0000_3008, 5'd7,  32'h0000_0103, 32'h80FF_7F01, 2'd1, 3'd2, 5'd7,  32'h0000_0080};
      vecs[3] = '{"lh2",       32'h0000_300C, 5'd9,  32'h0000_0102, 32'h80FF_7F01, 2'd1, 3'd3, 5'd9,  32'hFFFF_80FF};
      vecs[4] = '{"lhu0",      32'h0000_3010, 5'd10, 32'h0000_0100, 32'h80FF_7F01, 2'd1, 3'd4, 5'd10, 32'h0000_7F01};
      vecs[5] = '{"lb1",       32'h0000_3014, 5'd11, 32'h0000_0101, 32'h80FF_7F01, 2'd1, 3'd1, 5'd11, 32'h0000_007F};
      vecs[6] = '{"lw_lt6",    32'h0000_3018, 5'd12, 32'h0000_0102, 32'h80FF_7F01, 2'd1, 3'd6, 5'd12, 32'h80FF_7F01};
      vecs[7] = '{"link",      32'h0000_3000, 5'd31, 32'h0000_5555, 32'h0,         2'd2, 3'd0, 5'd31, 32'h0000_3008};
      vecs[8] = '{"linkwrap",  32'hFFFF_FFF8, 5'd31, 32'h0,         32'h0,         2'd2, 3'd0, 5'd31, 32'h0000_0000};
      vecs[9] = '{"rsvd_wra0", 32'h0000_3020, 5'd0,  32'h0000_ABCD, 32'h1234_5678, 2'd3, 3'd0, 5'd0,  32'h0000_0000};

      checks = 0; failures = 0;
      reset = 1'b0; W_hold = 0; W_flush = 0;
      set_m(32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd0, 3'd0);
      model_reset();
      #12;
      // Reset state
      chk("rst.W_WRA", {27'd0, W_WRA}, 32'd0);
      chk("rst.W_WRD", W_WRD, 32'd0);
      chk("rst.W_instruc", W_instruc, 32'd0);
      chk("rst.W_PCWhenWrite", W_PCWhenWrite, 32'd0);
      chk("rst.W_WRA_fwd", {27'd0, W_WRA_fwd}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Table vectors: one posedge from M to W
      for (int i = 0; i < 10; i++) begin
         set_m(32'h1000_0000 + i, vecs[i].pc, vecs[i].wra, vecs[i].alu, vecs[i].mem,
               vecs[i].sel, vecs[i].lt);
         step(0, 0);
         chk({vecs[i].name, ".W_WRA"}, {27'd0, W_WRA}, {27'd0, vecs[i].exp_wra});
         chk({vecs[i].name, ".W_WRD"}, W_WRD, vecs[i].exp_wrd);
         chk({vecs[i].name, ".W_Pass"}, W_Pass, vecs[i].exp_wrd);
         chk({vecs[i].name, ".W_PCWhenWrite"}, W_PCWhenWrite, vecs[i].pc);
         chk({vecs[i].name, ".W_instruc"}, W_instruc, 32'h1000_0000 + i);
      end

      // Hold for 3 cycles on WRA=8: exactly one GRF write
      set_m(32'h2000_0008, 32'h0000_4000, 5'd8, 32'h0000_00AA, 32'h0, 2'd0, 3'd0);
      step(0, 0);
      writes = (W_WRA != 0) ? 1 : 0;
      chk("hold.first.W_WRA", {27'd0, W_WRA}, 32'd8);
      set_m(32'h3333_3333, 32'h0000_5000, 5'd3, 32'h0000_0BAD, 32'h0, 2'd0, 3'd0);
      for (int c = 0; c < 3; c++) begin
         step(1, 0);
         if (W_WRA != 0) writes++;
         chk("hold.W_WRA", {27'd0, W_WRA}, 32'd0);
         chk("hold.W_WRA_fwd", {27'd0, W_WRA_fwd}, 32'd8);
         chk("hold.W_instruc", W_instruc, 32'h2000_0008);
         chk("hold.W_WRD", W_WRD, 32'h0000_00AA);
      end
      chk("hold.writes", writes, 32'd1);

      // Hold + flush: hold wins
      step(1, 1);
      chk("holdflush.W_instruc", W_instruc, 32'h2000_0008);
      chk("holdflush.W_WRA_fwd", {27'd0, W_WRA_fwd}, 32'd8);

      // Flush: nop loads
      step(0, 1);
      chk("flush.W_instruc", W_instruc, 32'd0);
      chk("flush.W_WRA", {27'd0, W_WRA}, 32'd0);
      chk("flush.W_WRD", W_WRD, 32'd0);

      // Async reset mid-cycle during a hold
      set_m(32'h4000_0004, 32'h0000_6000, 5'd4, 32'h0000_0044, 32'h0, 2'd0, 3'd0);
      step(0, 0);
      step(1, 0);
      chk("prerst.W_WRA_fwd", {27'd0, W_WRA_fwd}, 32'd4);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("arst.W_WRA_fwd", {27'd0, W_WRA_fwd}, 32'd0);
      chk("arst.W_WRA", {27'd0, W_WRA}, 32'd0);
      chk("arst.W_WRD", W_WRD, 32'd0);
      chk("arst.W_instruc", W_instruc, 32'd0);
      chk("arst.W_PCWhenWrite", W_PCWhenWrite, 32'd0);
`ifdef WB_RETIRE_CNT_EN
      chk("arst.W_retire_cnt", W_retire_cnt, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b1;
      W_hold = 0;

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         bit h, f;
         h = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 6) == 0);
         set_m(($urandom_range(0, 7) == 0) ? 32'h0 : $urandom(), $urandom(),
               5'($urandom_range(0, 31)), $urandom(), $urandom(),
               2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
         step(h, f);
         check_model("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
